// File: rtl/priority_encoder3.sv
// Registered 8-input fixed-priority encoder: reports the index of the highest
// asserted request line and whether any line is asserted, one cycle later.
module priority_encoder3 (
    input  logic       clk,
    input  logic       rst,
    input  logic       in0,
    input  logic       in1,
    input  logic       in2,
    input  logic       in3,
    input  logic       in4,
    input  logic       in5,
    input  logic       in6,
    input  logic       in7,
    output logic [2:0] num,
    output logic       any
);

    logic [7:0] req_s;
    logic [2:0] num_d;
    logic       any_d;
    logic [2:0] num_q;
    logic       any_q;

    // Highest set bit wins; an all-zero vector encodes to 0 and is told apart by any.
    function automatic logic [2:0] encode_hi(input logic [7:0] req);
        logic [2:0] idx;
        casez (req)
            8'b1???????: idx = 3'd7;
            8'b01??????: idx = 3'd6;
            8'b001?????: idx = 3'd5;
            8'b0001????: idx = 3'd4;
            8'b00001???: idx = 3'd3;
            8'b000001??: idx = 3'd2;
            8'b0000001?: idx = 3'd1;
            8'b00000001: idx = 3'd0;
            default:     idx = 3'd0;
        endcase
        return idx;
    endfunction

    assign req_s = {in7, in6, in5, in4, in3, in2, in1, in0};

    // Next-state encode of this cycle's sampled requests.
    always_comb begin
        num_d = encode_hi(req_s);
        any_d = |req_s;
    end

    // Single output register stage with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            num_q <= 3'd0;
            any_q <= 1'b0;
        end else begin
            num_q <= num_d;
            any_q <= any_d;
        end
    end

    assign num = num_q;
    assign any = any_q;

endmodule

// File: tb/tb_priority_encoder3.sv
// Scoreboard bench for priority_encoder3: the driver queues expected {any,num}
// per issued cycle and an independent monitor pops and compares after each edge.
module tb_priority_encoder3;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [2:0] num;
    logic       any;

    typedef struct {
        logic [3:0] exp;
        string      tag;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       checks;
    int       failures;

    priority_encoder3 dut (
        .clk (clk),
        .rst (rst),
        .in0 (req[0]),
        .in1 (req[1]),
        .in2 (req[2]),
        .in3 (req[3]),
        .in4 (req[4]),
        .in5 (req[5]),
        .in6 (req[6]),
        .in7 (req[7]),
        .num (num),
        .any (any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: scan upward so the last set bit seen is the highest one.
    function automatic logic [3:0] ref_model(input logic [7:0] v);
        logic [2:0] n;
        logic       a;
        n = 3'd0;
        a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                n = i[2:0];
                a = 1'b1;
            end
        end
        return {a, n};
    endfunction

    task automatic step(input logic [7:0] v, input logic r, input logic [3:0] exp, input string tag);
        sb_item_t it;
        @(negedge clk);
        req = v;
        rst = r;
        it.exp = exp;
        it.tag = tag;
        sb_q.push_back(it);
    endtask

    // Monitor: every edge, compare the registered outputs with the oldest expectation.
    initial begin
        sb_item_t it;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                checks++;
                if ({any, num} !== it.exp) begin
                    failures++;
                    $display("FAIL %s: got any=%b num=%b, expected any=%b num=%b",
                             it.tag, any, num, it.exp[3], it.exp[2:0]);
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        req      = 8'h00;

        step(8'hFF, 1'b1, 4'b0_000, "reset_holds_zero");
        step(8'h00, 1'b0, 4'b0_000, "none_asserted");
        step(8'h01, 1'b0, 4'b1_000, "in0_only");
        step(8'h04, 1'b0, 4'b1_010, "in2_only");
        step(8'h12, 1'b0, 4'b1_100, "in4_beats_in1");
        step(8'hFF, 1'b0, 4'b1_111, "all_asserted");
        step(8'h7E, 1'b0, 4'b1_110, "in6_beats_lower");
        step(8'h81, 1'b0, 4'b1_111, "in7_beats_in0");

        step(8'h01, 1'b0, 4'b1_000, "walk_in0");
        step(8'h02, 1'b0, 4'b1_001, "walk_in1");
        step(8'h04, 1'b0, 4'b1_010, "walk_in2");
        step(8'h08, 1'b0, 4'b1_011, "walk_in3");
        step(8'h10, 1'b0, 4'b1_100, "walk_in4");
        step(8'h20, 1'b0, 4'b1_101, "walk_in5");
        step(8'h40, 1'b0, 4'b1_110, "walk_in6");
        step(8'h80, 1'b0, 4'b1_111, "walk_in7");

        step(8'h80, 1'b1, 4'b0_000, "midstream_reset");
        step(8'h80, 1'b0, 4'b1_111, "after_reset_release");
        step(8'h00, 1'b0, 4'b0_000, "back_to_none");

        for (int p = 0; p < 256; p++) begin
            logic [7:0] pv;
            pv = p[7:0];
            step(pv, 1'b0, ref_model(pv), $sformatf("sweep_%02h", pv));
        end

        step(8'h03, 1'b0, 4'b1_001, "post_sweep_in1");

        wait_cycles = 0;
        while (sb_q.size() > 0 && wait_cycles < 8) begin
            @(posedge clk);
            wait_cycles++;
        end
        @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
